fwd_bypass_network: RTL and testbench

//  Parametrised operand-bypass network for the 5-stage MIPS pipeline.
//  - Replaces the fixed 3:1 Forward A/B operand muxes with a tracked history of in-flight writebacks.
//  - Selects the youngest matching in-flight result per operand port.
//  - Raises a load-use stall when the matching producer is a load whose data has not yet returned.
//  - Sits between the ID/EX register-file read outputs and the ALU-source muxes.

---
 rtl/mips_pipe_pkg.sv | 18 +
 rtl/bypass_select.sv | 47 ++++
 rtl/fwd_bypass_network.sv | 88 ++++++++
 tb/tb_fwd_bypass_network.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types and constants for the 5-stage MIPS datapath.
// Widths here are the defaults used by regDst, writeback and bypass logic.
package mips_pipe_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;

    localparam logic [DEF_REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                      valid;
        logic                      is_load;
        logic                      ready;
        logic [DEF_REG_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0]     data;
    } fwd_entry_t;

endpackage

// File: rtl/bypass_select.sv
// Priority match of one operand port against the writeback history.
// Slot 0 is the youngest entry and wins over every older slot.
module bypass_select
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int DEPTH      = 3
) (
    input  logic [REG_ADDR_W-1:0]       op_addr,
    input  logic [DATA_W-1:0]           rf_data,
    input  logic [DEPTH-1:0]            ent_valid,
    input  logic [DEPTH-1:0]            ent_load,
    input  logic [DEPTH-1:0]            ent_ready,
    input  logic [DEPTH*REG_ADDR_W-1:0] ent_addr,
    input  logic [DEPTH*DATA_W-1:0]     ent_data,
    output logic [DATA_W-1:0]           op_data,
    output logic                        fwd_hit,
    output logic                        stall_req
);

    logic nonzero;

    assign nonzero = (op_addr != REG_ADDR_W'(REG_ZERO));

    // Walk oldest to youngest so a younger match overrides an older one.
    always_comb begin
        op_data   = rf_data;
        fwd_hit   = 1'b0;
        stall_req = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && nonzero &&
                ent_addr[i*REG_ADDR_W +: REG_ADDR_W] == op_addr) begin
                if (ent_ready[i]) begin
                    op_data   = ent_data[i*DATA_W +: DATA_W];
                    fwd_hit   = 1'b1;
                    stall_req = 1'b0;
                end else begin
                    op_data   = rf_data;
                    fwd_hit   = 1'b0;
                    stall_req = ent_load[i];
                end
            end
        end
    end

endmodule

// File: rtl/fwd_bypass_network.sv
// Operand bypass network: history of in-flight writebacks plus
// per-port youngest-match selection and load-use stall detection.
module fwd_bypass_network
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_PORTS  = 2,
    parameter int DEPTH      = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            freeze,
    input  logic                            push_valid,
    input  logic                            push_kill,
    input  logic                            push_is_load,
    input  logic [REG_ADDR_W-1:0]           push_addr,
    input  logic [DATA_W-1:0]               push_data,
    input  logic [DATA_W-1:0]               mem_rdata,
    input  logic [NUM_PORTS*REG_ADDR_W-1:0] op_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]     rf_data,
    output logic [NUM_PORTS*DATA_W-1:0]     op_data,
    output logic [NUM_PORTS-1:0]            fwd_hit,
    output logic                            hazard_stall
);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            load_q, load_d;
    logic [DEPTH-1:0]            ready_q, ready_d;
    logic [DEPTH*REG_ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH*DATA_W-1:0]     data_q, data_d;
    logic [NUM_PORTS-1:0]        stall_req;
    logic                        push_ok;

    assign push_ok = push_valid && !push_kill &&
                     (push_addr != REG_ADDR_W'(REG_ZERO));

    always_comb begin
        valid_d = {valid_q[DEPTH-2:0], push_ok};
        load_d  = {load_q[DEPTH-2:0], push_is_load};
        ready_d = {ready_q[DEPTH-2:0], !push_is_load};
        addr_d  = {addr_q[(DEPTH-1)*REG_ADDR_W-1:0], push_addr};
        data_d  = {data_q[(DEPTH-1)*DATA_W-1:0], push_data};
        // A pending load picks up its memory data on the way into slot 1.
        if (!ready_q[0]) begin
            data_d[DATA_W +: DATA_W] = mem_rdata;
        end
        ready_d[1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            load_q  <= '0;
            ready_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (!freeze) begin
            valid_q <= valid_d;
            load_q  <= load_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        bypass_select #(
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH)
        ) u_sel (
            .op_addr   (op_addr[p*REG_ADDR_W +: REG_ADDR_W]),
            .rf_data   (rf_data[p*DATA_W +: DATA_W]),
            .ent_valid (valid_q),
            .ent_load  (load_q),
            .ent_ready (ready_q),
            .ent_addr  (addr_q),
            .ent_data  (data_q),
            .op_data   (op_data[p*DATA_W +: DATA_W]),
            .fwd_hit   (fwd_hit[p]),
            .stall_req (stall_req[p])
        );
    end

    assign hazard_stall = |stall_req;

endmodule

// File: tb/tb_fwd_bypass_network.sv
// Scoreboard bench: directed scenarios then random traffic checked
// against a queue-of-writes reference model.
module tb_fwd_bypass_network;

    logic        clk = 1'b0;
    logic        rst, freeze, push_valid, push_kill, push_is_load;
    logic [4:0]  push_addr;
    logic [31:0] push_data, mem_rdata;
    logic [9:0]  op_addr;
    logic [63:0] rf_data;
    logic [63:0] op_data;
    logic [1:0]  fwd_hit;
    logic        hazard_stall;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          valid;
        bit          ready;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  hit;
        logic        stall;
    } exp_t;

    wr_t  hist[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    fwd_bypass_network dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .push_valid   (push_valid),
        .push_kill    (push_kill),
        .push_is_load (push_is_load),
        .push_addr    (push_addr),
        .push_data    (push_data),
        .mem_rdata    (mem_rdata),
        .op_addr      (op_addr),
        .rf_data      (rf_data),
        .op_data      (op_data),
        .fwd_hit      (fwd_hit),
        .hazard_stall (hazard_stall)
    );

    // Youngest in-flight write to the register decides the operand.
    function automatic exp_t predict();
        exp_t e;
        e.data  = rf_data;
        e.hit   = 2'b00;
        e.stall = 1'b0;
        for (int p = 0; p < 2; p++) begin
            logic [4:0] a;
            a = op_addr[p*5 +: 5];
            for (int k = 0; k < hist.size(); k++) begin
                if (hist[k].valid && a != 5'd0 && hist[k].addr == a) begin
                    if (hist[k].ready) begin
                        e.data[p*32 +: 32] = hist[k].data;
                        e.hit[p] = 1'b1;
                    end else begin
                        e.stall = 1'b1;
                    end
                    break;
                end
            end
        end
        return e;
    endfunction

    task automatic set_idle();
        rst = 0; freeze = 0;
        push_valid = 0; push_kill = 0; push_is_load = 0;
        push_addr = 0; push_data = 0; mem_rdata = 0;
        op_addr = 0; rf_data = 0;
    endtask

    task automatic issue(output exp_t e);
        e = predict();
        sb.push_back(e);
    endtask

    task automatic tick();
        wr_t w;
        @(posedge clk);
        if (rst) begin
            hist.delete();
        end else if (!freeze) begin
            if (hist.size() > 0 && !hist[0].ready) begin
                hist[0].data  = mem_rdata;
                hist[0].ready = 1'b1;
            end
            w.valid = push_valid && !push_kill && push_addr != 5'd0;
            w.ready = !push_is_load;
            w.addr  = push_addr;
            w.data  = push_data;
            hist.push_front(w);
            if (hist.size() > 3) void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic cchk(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (op_data !== e.data || fwd_hit !== e.hit ||
                hazard_stall !== e.stall) begin
                failures++;
                $display("FAIL sb got=%h/%b/%b want=%h/%b/%b",
                         op_data, fwd_hit, hazard_stall,
                         e.data, e.hit, e.stall);
            end
        end
    end

    task automatic push(logic [4:0] a, logic [31:0] d);
        set_idle();
        push_valid = 1; push_addr = a; push_data = d;
    endtask

    initial begin
        exp_t e;
        bit last_stall;
        set_idle();
        rst = 1;
        tick();
        tick();

        set_idle();
        rf_data = {32'h7, 32'h5};
        issue(e); @(negedge clk);
        cchk("rst_data", op_data, {32'h7, 32'h5});
        cchk("rst_flags", {fwd_hit, hazard_stall}, 3'b000);
        tick();

        push(3, 32'h11); issue(e); tick();
        set_idle(); op_addr = 10'd3; issue(e); @(negedge clk);
        cchk("exex", {op_data[31:0], fwd_hit[0]}, {32'h11, 1'b1});
        tick();

        push(3, 32'hA); issue(e); tick();
        push(3, 32'hB); issue(e); tick();
        for (int s = 0; s < 4; s++) begin
            set_idle(); op_addr = 10'd3; rf_data = 64'h1234;
            issue(e); @(negedge clk);
            cchk($sformatf("young%0d", s), op_data[31:0],
                 (s == 3) ? 32'h1234 : 32'hB);
            tick();
        end

        push(5, 32'h0); push_is_load = 1; issue(e); tick();
        set_idle(); op_addr = 10'd5; rf_data = 64'h77;
        mem_rdata = 32'hDEAD; issue(e); @(negedge clk);
        cchk("lu_stall", {hazard_stall, fwd_hit[0], op_data[31:0]},
             {1'b1, 1'b0, 32'h77});
        tick();
        set_idle(); op_addr = 10'd5; rf_data = 64'h77;
        issue(e); @(negedge clk);
        cchk("lu_data", {hazard_stall, fwd_hit[0], op_data[31:0]},
             {1'b0, 1'b1, 32'hDEAD});
        tick();

        push(0, 32'hFF); issue(e); tick();
        set_idle(); op_addr = 10'd0; rf_data = 64'h123;
        issue(e); @(negedge clk);
        cchk("r0", {fwd_hit[0], op_data[31:0]}, {1'b0, 32'h123});
        tick();
        push(4, 32'h44); push_kill = 1; issue(e); tick();
        set_idle(); op_addr = {5'd4, 5'd4}; rf_data = {32'h9, 32'h8};
        issue(e); @(negedge clk);
        cchk("kill", {fwd_hit, op_data}, {2'b00, 32'h9, 32'h8});
        tick();

        push(6, 32'h66); issue(e); tick();
        for (int s = 0; s < 4; s++) begin
            set_idle(); freeze = 1; rst = (s == 3);
            op_addr = {5'd6, 5'd6}; rf_data = 64'h99;
            issue(e); @(negedge clk);
            cchk($sformatf("frz%0d", s), {fwd_hit, op_data},
                 {2'b11, 32'h66, 32'h66});
            tick();
        end
        set_idle(); op_addr = {5'd6, 5'd6}; rf_data = {32'h98, 32'h99};
        issue(e); @(negedge clk);
        cchk("frz_rst", {fwd_hit, hazard_stall, op_data},
             {3'b000, 32'h98, 32'h99});
        tick();

        last_stall = 0;
        for (int n = 0; n < 600; n++) begin
            set_idle();
            rst    = ($urandom_range(0, 99) == 0);
            freeze = ($urandom_range(0, 9) == 0);
            push_valid   = !last_stall && ($urandom_range(0, 3) != 0);
            push_kill    = ($urandom_range(0, 7) == 0);
            push_is_load = ($urandom_range(0, 2) == 0);
            push_addr    = 5'($urandom_range(0, 7));
            push_data    = $urandom;
            mem_rdata    = $urandom;
            op_addr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rf_data      = {$urandom, $urandom};
            issue(e);
            last_stall = e.stall;
            tick();
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
